reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Staged reset-release sequencer downstream of the DDSFG reset generator. Waits for the PLL lock and the generator's function-generator reset release to be stable, then releases the DAC interface, DDS core and control logic resets in that order with fixed gaps. Re-asserts all stage resets on lock loss or on a software reset request. Counts lock-loss events for status readback.

## Interface
Parameters:
- LOCK_STABLE, 1024, consecutive cycles synced lock and Fg release must hold before stage 0 is released (≥2)
- STAGE_GAP, 16, cycles between successive stage releases, and SW hold length (≥1)
- LOSS_W, 8, width of lock-loss counter

Ports:
- CLK  in  1  system clock (PLL output domain)
- RESET  in  1  asynchronous, active-high reset
- PllLocked  in  1  raw PLL lock, asynchronous; 2-FF synchronized inside
- Fg_RESETn  in  1  reset from reset generator, active-low, asynchronous; 2-FF synchronized inside
- SwRstReq  in  1  single-cycle software reset request, CLK domain
- StageRESETn  out  3  active-low stage resets: [0] DAC interface, [1] DDS core, [2] control/UI
- SeqDone  out  1  high when all stages released (RUN)
- SeqState  out  2  current state encoding
- LockLossCnt  out  LOSS_W  saturating count of lock-loss events

## Operation
- ok = lock_s & fg_s (synchronized inputs).
- States: WAIT_LOCK=0, RELEASE=1, RUN=2, SW_HOLD=3.
- WAIT_LOCK: StageRESETn=000. Stable counter increments while ok, clears when !ok. When counter reaches LOCK_STABLE-1 with ok, → RELEASE, StageRESETn[0]=1 on that edge; gap counter cleared.
- RELEASE: gap counter counts 0..STAGE_GAP-1; on wrap releases next stage bit. Releasing bit 2 → RUN, SeqDone=1 on the same edge.
- RUN: all outputs held released.
- SwRstReq in RELEASE or RUN (with ok): next edge StageRESETn=000, SeqDone=0, → SW_HOLD. SW_HOLD holds STAGE_GAP cycles, then → RELEASE with bit 0 released on exit edge. SwRstReq in WAIT_LOCK or SW_HOLD ignored (SW_HOLD not restarted).
- Lock loss: !ok in RELEASE, RUN or SW_HOLD → next edge StageRESETn=000, SeqDone=0, → WAIT_LOCK, stable counter cleared, LockLossCnt+1 saturating at 2^LOSS_W-1. Lock loss has priority over SwRstReq in the same cycle.
- Resets only ever release in order 0→1→2; assertion is always all three on one edge.

## Timing
- Async RESET: state WAIT_LOCK, StageRESETn=000, SeqDone=0, SeqState=0, LockLossCnt=0, synchronizers and counters 0.
- Input sync latency 2 cycles: raw rising at edge k seen as ok at edge k+2.
- Lock-to-stage-0: StageRESETn[0] rises LOCK_STABLE edges after the first edge where ok is sampled high; [1] STAGE_GAP edges later; [2] and SeqDone another STAGE_GAP later.
- Raw lock fall → all resets asserted 3 edges later (2 sync + 1 register).
- SwRstReq sampled at edge n → resets asserted at edge n+1 (registered), bit 0 re-released at edge n+1+STAGE_GAP if ok held.
- All outputs registered; no combinational input→output paths.

## Structure
- Shared package rst_seq_pkg: state encoding localparams (WAIT_LOCK..SW_HOLD), stage index constants (STG_DAC=0, STG_DDS=1, STG_CTL=2), stage count 3.
- Counter widths $clog2(LOCK_STABLE), $clog2(STAGE_GAP+1).
- Sub-module sync_2ff (async clear on RESET), instantiated for PllLocked and Fg_RESETn.

## Test plan
LOCK_STABLE=8, STAGE_GAP=4, LOSS_W=4 for all:
- Power-up: RESET high 5 cycles, release, raise PllLocked and Fg_RESETn at edge 10 → ok at 12; StageRESETn 001 at 20, 011 at 24, 111 and SeqDone at 28.
- Glitch: lock high 5 cycles, low 1, high again → stable counter restarts; StageRESETn[0] rises 8 edges after the second ok rise; LockLossCnt stays 0.
- Lock loss in RUN: drop PllLocked at edge 40 → StageRESETn=000, SeqDone=0 at 43, LockLossCnt=1, state WAIT_LOCK; re-lock repeats full sequence.
- SwRstReq in RUN at edge 50 → 000 at 51; 001 at 55, 011 at 59, 111 at 63; LockLossCnt unchanged.
- Simultaneous SwRstReq and lock loss → WAIT_LOCK, LockLossCnt increments; 16 further losses → LockLossCnt saturates at 15.
- RESET asserted mid-RELEASE (StageRESETn=011) → all outputs zero immediately, asynchronously, state 0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared encodings for the staged reset sequencer:
// FSM state values and stage bit positions.
package rst_seq_pkg;

   localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
   localparam logic [1:0] ST_RELEASE   = 2'd1;
   localparam logic [1:0] ST_RUN       = 2'd2;
   localparam logic [1:0] ST_SW_HOLD   = 2'd3;

   typedef enum logic [1:0] {
      WAIT_LOCK = ST_WAIT_LOCK,
      RELEASE   = ST_RELEASE,
      RUN       = ST_RUN,
      SW_HOLD   = ST_SW_HOLD
   } seq_state_e;

   localparam int unsigned STG_DAC    = 0;
   localparam int unsigned STG_DDS    = 1;
   localparam int unsigned STG_CTL    = 2;
   localparam int unsigned NUM_STAGES = 3;

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs;
// cleared to 0 by the sequencer's asynchronous reset.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset-release sequencer: waits for stable lock and generator
// release, then frees DAC, DDS and control resets in order.
module reset_sequencer
   import rst_seq_pkg::*;
#(
   parameter int unsigned LOCK_STABLE = 1024,
   parameter int unsigned STAGE_GAP   = 16,
   parameter int unsigned LOSS_W      = 8
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  PllLocked,
   input  logic                  Fg_RESETn,
   input  logic                  SwRstReq,
   output logic [NUM_STAGES-1:0] StageRESETn,
   output logic                  SeqDone,
   output logic [1:0]            SeqState,
   output logic [LOSS_W-1:0]     LockLossCnt
);

   localparam int unsigned SW = $clog2(LOCK_STABLE);
   localparam int unsigned GW = $clog2(STAGE_GAP + 1);

   localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

   seq_state_e            state_q, state_d;
   logic [SW-1:0]         stab_q, stab_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic [NUM_STAGES-1:0] stg_q, stg_d;
   logic                  done_q, done_d;
   logic [LOSS_W-1:0]     loss_q, loss_d;

   logic lock_s;
   logic fg_s;
   logic ok;
   logic lose;
   logic sw_take;

   sync_2ff u_sync_lock (
      .clk_i (CLK),
      .rst_i (RESET),
      .d_i   (PllLocked),
      .q_o   (lock_s)
   );

   sync_2ff u_sync_fg (
      .clk_i (CLK),
      .rst_i (RESET),
      .d_i   (Fg_RESETn),
      .q_o   (fg_s)
   );

   assign ok      = lock_s & fg_s;
   assign lose    = !ok && (state_q != WAIT_LOCK);
   assign sw_take = SwRstReq &&
                    (state_q == RELEASE || state_q == RUN);

   // Lock loss outranks a software request in the same cycle.
   always_comb begin
      state_d = state_q;
      stab_d  = stab_q;
      gap_d   = gap_q;
      stg_d   = stg_q;
      done_d  = done_q;
      loss_d  = loss_q;
      if (lose) begin
         state_d = WAIT_LOCK;
         stab_d  = '0;
         stg_d   = '0;
         done_d  = 1'b0;
         if (loss_q != '1) begin
            loss_d = loss_q + LOSS_W'(1);
         end
      end else if (sw_take) begin
         state_d = SW_HOLD;
         gap_d   = '0;
         stg_d   = '0;
         done_d  = 1'b0;
      end else begin
         unique case (state_q)
            WAIT_LOCK: begin
               if (!ok) begin
                  stab_d = '0;
               end else if (stab_q == STAB_LAST) begin
                  state_d        = RELEASE;
                  stab_d         = '0;
                  gap_d          = '0;
                  stg_d          = '0;
                  stg_d[STG_DAC] = 1'b1;
               end else begin
                  stab_d = stab_q + SW'(1);
               end
            end
            RELEASE: begin
               if (gap_q == GAP_LAST) begin
                  gap_d = '0;
                  stg_d = {stg_q[NUM_STAGES-2:0], 1'b1};
                  if (stg_q[STG_DDS]) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end
            SW_HOLD: begin
               if (gap_q == GAP_LAST) begin
                  state_d        = RELEASE;
                  gap_d          = '0;
                  stg_d          = '0;
                  stg_d[STG_DAC] = 1'b1;
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= WAIT_LOCK;
         stab_q  <= '0;
         gap_q   <= '0;
         stg_q   <= '0;
         done_q  <= 1'b0;
         loss_q  <= '0;
      end else begin
         state_q <= state_d;
         stab_q  <= stab_d;
         gap_q   <= gap_d;
         stg_q   <= stg_d;
         done_q  <= done_d;
         loss_q  <= loss_d;
      end
   end

   assign StageRESETn = stg_q;
   assign SeqDone     = done_q;
   assign SeqState    = state_q;
   assign LockLossCnt = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: scenario tasks plus random traffic,
// checked against a timeline model of the release sequence.
module tb_reset_sequencer;

   localparam int LS   = 8;
   localparam int GAP  = 4;
   localparam int LW   = 4;
   localparam int LMAX = (1 << LW) - 1;

   // mode: 0 waiting for lock, 1 releasing/running, 2 software hold
   typedef struct {
      int         mode;
      int         stab;
      int         t;
      int         h;
      int         loss;
      logic [1:0] hl;
      logic [1:0] hf;
   } model_t;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          PllLocked = 1'b0;
   logic          Fg_RESETn = 1'b0;
   logic          SwRstReq = 1'b0;
   logic [2:0]    StageRESETn;
   logic          SeqDone;
   logic [1:0]    SeqState;
   logic [LW-1:0] LockLossCnt;

   int     n_chk = 0;
   int     n_fail = 0;
   int     ecnt;
   model_t mdl;
   logic [9:0] obs;
   logic [9:0] expv;

   always #5 CLK = ~CLK;

   reset_sequencer #(
      .LOCK_STABLE (LS),
      .STAGE_GAP   (GAP),
      .LOSS_W      (LW)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .PllLocked   (PllLocked),
      .Fg_RESETn   (Fg_RESETn),
      .SwRstReq    (SwRstReq),
      .StageRESETn (StageRESETn),
      .SeqDone     (SeqDone),
      .SeqState    (SeqState),
      .LockLossCnt (LockLossCnt)
   );

   function automatic model_t mdl_clear();
      model_t m;
      m.mode = 0;
      m.stab = 0;
      m.t    = 0;
      m.h    = 0;
      m.loss = 0;
      m.hl   = 2'b00;
      m.hf   = 2'b00;
      return m;
   endfunction

   function automatic model_t mdl_step(model_t m, logic l,
                                       logic f, logic s);
      model_t n;
      logic   ok;
      n    = m;
      ok   = m.hl[1] & m.hf[1];
      n.hl = {m.hl[0], l};
      n.hf = {m.hf[0], f};
      if (m.mode != 0 && !ok) begin
         n.mode = 0;
         n.stab = 0;
         if (m.loss < LMAX) n.loss = m.loss + 1;
      end else begin
         case (m.mode)
            0: begin
               if (!ok) n.stab = 0;
               else if (m.stab == LS - 1) begin
                  n.mode = 1;
                  n.t    = 0;
                  n.stab = 0;
               end else n.stab = m.stab + 1;
            end
            1: begin
               if (s) begin
                  n.mode = 2;
                  n.h    = 0;
               end else if (m.t < 2 * GAP) n.t = m.t + 1;
            end
            default: begin
               if (m.h == GAP - 1) begin
                  n.mode = 1;
                  n.t    = 0;
               end else n.h = m.h + 1;
            end
         endcase
      end
      return n;
   endfunction

   // Outputs follow from how long ago stage 0 was freed.
   function automatic logic [9:0] exp_vec(model_t m);
      int         n;
      logic [2:0] stg;
      logic       done;
      logic [1:0] st;
      stg  = 3'b000;
      done = 1'b0;
      st   = 2'd0;
      if (m.mode == 2) st = 2'd3;
      else if (m.mode == 1) begin
         n = 1 + m.t / GAP;
         if (n > 3) n = 3;
         stg  = 3'((1 << n) - 1);
         done = (n == 3);
         st   = (n == 3) ? 2'd2 : 2'd1;
      end
      return {stg, done, st, 4'(m.loss)};
   endfunction

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mdl  <= mdl_clear();
         ecnt <= 0;
      end else begin
         mdl  <= mdl_step(mdl, PllLocked, Fg_RESETn, SwRstReq);
         ecnt <= ecnt + 1;
      end
   end

   assign obs = {StageRESETn, SeqDone, SeqState, LockLossCnt};
   always_comb expv = exp_vec(mdl);

   task automatic to_edge(input int k);
      while (ecnt < k) @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET     = 1'b1;
      PllLocked = 1'b0;
      Fg_RESETn = 1'b0;
      SwRstReq  = 1'b0;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (5) @(negedge CLK);
      n_chk++;
      if (obs !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_state got %b exp %b", obs, 10'd0);
      end
      RESET = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         to_edge(e);
         n_chk++;
         if (obs !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_hold e=%0d got %b exp %b",
                     e, obs, 10'd0);
         end
      end
   endtask

   task automatic test_powerup();
      logic [3:0] want;
      for (int e = 4; e <= 31; e++) begin
         to_edge(e);
         n_chk++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL pwr_model e=%0d got %b exp %b",
                     e, obs, expv);
         end
         if (e inside {19, 20, 23, 24, 27, 28}) begin
            want = (e == 19) ? 4'b0000 :
                   (e <= 23) ? 4'b0010 :
                   (e <= 27) ? 4'b0110 : 4'b1111;
            n_chk++;
            if ({StageRESETn, SeqDone} !== want) begin
               n_fail++;
               $display("FAIL pwr_time e=%0d got %b exp %b",
                        e, {StageRESETn, SeqDone}, want);
            end
         end
         if (e == 10) begin
            PllLocked = 1'b1;
            Fg_RESETn = 1'b1;
         end
      end
   endtask

   task automatic test_lock_loss();
      logic [3:0] want;
      for (int e = 32; e <= 70; e++) begin
         to_edge(e);
         n_chk++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL loss_model e=%0d got %b exp %b",
                     e, obs, expv);
         end
         if (e == 42 || e == 43) begin
            want = (e == 42) ? 4'b1111 : 4'b0000;
            n_chk++;
            if ({StageRESETn, SeqDone} !== want ||
                (e == 43 && {SeqState, LockLossCnt} !== 6'h01)) begin
               n_fail++;
               $display("FAIL loss_time e=%0d got %b exp %b%b",
                        e, obs, want, (e == 43) ? 6'h01 : 6'h21);
            end
         end
         if (e inside {56, 60, 64}) begin
            want = (e == 56) ? 4'b0010 :
                   (e == 60) ? 4'b0110 : 4'b1111;
            n_chk++;
            if ({StageRESETn, SeqDone} !== want) begin
               n_fail++;
               $display("FAIL relock_time e=%0d got %b exp %b",
                        e, {StageRESETn, SeqDone}, want);
            end
         end
         if (e == 40) PllLocked = 1'b0;
         if (e == 46) PllLocked = 1'b1;
      end
   endtask

   task automatic test_sw_run();
      logic [9:0] want;
      for (int e = 70; e <= 90; e++) begin
         to_edge(e);
         n_chk++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL sw_model e=%0d got %b exp %b",
                     e, obs, expv);
         end
         if (e inside {71, 74, 75, 79, 83}) begin
            want = (e <= 74) ? {3'b000, 1'b0, 2'd3, 4'd1} :
                   (e == 75) ? {3'b001, 1'b0, 2'd1, 4'd1} :
                   (e == 79) ? {3'b011, 1'b0, 2'd1, 4'd1} :
                               {3'b111, 1'b1, 2'd2, 4'd1};
            n_chk++;
            if (obs !== want) begin
               n_fail++;
               $display("FAIL sw_time e=%0d got %b exp %b",
                        e, obs, want);
            end
         end
         SwRstReq = (e == 70);
      end
   endtask

   task automatic test_simul();
      for (int e = 91; e <= 100; e++) begin
         to_edge(e);
         n_chk++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL simul_model e=%0d got %b exp %b",
                     e, obs, expv);
         end
         if (e == 95) begin
            n_chk++;
            if (obs !== {3'b000, 1'b0, 2'd0, 4'd2}) begin
               n_fail++;
               $display("FAIL simul_time got %b exp %b",
                        obs, {3'b000, 1'b0, 2'd0, 4'd2});
            end
         end
         if (e == 92) PllLocked = 1'b0;
         SwRstReq = (e == 94);
      end
   endtask

   task automatic test_saturate();
      int b;
      b = ecnt + 1;
      for (int k = 0; k < 16 * 16 + 4; k++) begin
         to_edge(b + k);
         n_chk++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL sat_model k=%0d got %b exp %b",
                     k, obs, expv);
         end
         PllLocked = (k < 256) && ((k % 16) < 11);
      end
      n_chk++;
      if (LockLossCnt !== 4'hF || SeqState !== 2'd0) begin
         n_fail++;
         $display("FAIL sat_final got cnt=%0d st=%0d exp cnt=15 st=0",
                  LockLossCnt, SeqState);
      end
   endtask

   task automatic test_glitch();
      do_reset();
      for (int e = 1; e <= 24; e++) begin
         to_edge(e);
         n_chk++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL glitch_model e=%0d got %b exp %b",
                     e, obs, expv);
         end
         if (e == 20 || e == 21) begin
            n_chk++;
            if (obs !== ((e == 20) ? 10'd0 :
                         {3'b001, 1'b0, 2'd1, 4'd0})) begin
               n_fail++;
               $display("FAIL glitch_time e=%0d got %b", e, obs);
            end
         end
         PllLocked = (e >= 5) && (e != 10);
         Fg_RESETn = (e >= 5);
      end
   endtask

   task automatic test_random();
      logic l;
      logic f;
      do_reset();
      l = 1'b1;
      f = 1'b1;
      for (int k = 1; k <= 3000; k++) begin
         to_edge(k);
         n_chk++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL rand_model k=%0d got %b exp %b",
                     k, obs, expv);
         end
         if (l && $urandom_range(0, 59) == 0) l = 1'b0;
         else if (!l && $urandom_range(0, 7) == 0) l = 1'b1;
         if (f && $urandom_range(0, 299) == 0) f = 1'b0;
         else if (!f && $urandom_range(0, 4) == 0) f = 1'b1;
         PllLocked = l;
         Fg_RESETn = f;
         SwRstReq  = ($urandom_range(0, 19) == 0);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int e = 1; e <= 25; e++) begin
         to_edge(e);
         n_chk++;
         if (obs !== expv) begin
            n_fail++;
            $display("FAIL mid_model e=%0d got %b exp %b",
                     e, obs, expv);
         end
         if (e == 10) begin
            PllLocked = 1'b1;
            Fg_RESETn = 1'b1;
         end
      end
      n_chk++;
      if (StageRESETn !== 3'b011) begin
         n_fail++;
         $display("FAIL mid_pre got %b exp 011", StageRESETn);
      end
      #2 RESET = 1'b1;
      #1;
      n_chk++;
      if (obs !== 10'd0) begin
         n_fail++;
         $display("FAIL mid_async got %b exp %b", obs, 10'd0);
      end
      @(negedge CLK);
      n_chk++;
      if (obs !== 10'd0) begin
         n_fail++;
         $display("FAIL mid_hold got %b exp %b", obs, 10'd0);
      end
      RESET = 1'b0;
   endtask

   initial begin
      test_reset();
      test_powerup();
      test_lock_loss();
      test_sw_run();
      test_simul();
      test_saturate();
      test_glitch();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
